// File: rtl/nn_pkg.sv
// Shared neuron-control definitions: phase pin encodings, sequencer states, Q8.8 constants.
package nn_pkg;

  localparam logic [1:0] PH_FSETUP = 2'b00;
  localparam logic [1:0] PH_FWD    = 2'b10;
  localparam logic [1:0] PH_BSETUP = 2'b11;
  localparam logic [1:0] PH_BWD    = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_ERR,
    ST_BWD,
    ST_DONE
  } state_t;

  localparam logic [15:0] Q_ONE = 16'h0100;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

endpackage

// File: rtl/train_step_ctrl_sat_sub.sv
// Combinational signed saturating subtract o_y = sat(i_a - i_b), no rounding.
// Latency 0; no flow control.
module sat_sub #(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic [BITS-1:0] o_y
);

  logic [BITS:0] w_diff;

  assign w_diff = {i_a[BITS-1], i_a} - {i_b[BITS-1], i_b};

  // Overflow shows as disagreement between the two top bits; the extra bit is the true sign.
  always_comb begin
    o_y = w_diff[BITS-1:0];
    if (w_diff[BITS] != w_diff[BITS-1]) begin
      o_y = w_diff[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    end
  end

endmodule

// File: rtl/train_step_ctrl.sv
// Output-neuron training sequencer: FWD -> ERR -> BWD -> DONE per start, with saturated error y - target.
// All outputs registered; start only accepted in IDLE, ignored (not queued) elsewhere.
module train_step_ctrl
  import nn_pkg::*;
#(
  parameter int N       = 6,
  parameter int BITS    = 16,
  parameter int FWD_LEN = N / 2 + 3,
  parameter int BWD_LEN = N + 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] target,
  input  logic [BITS-1:0] lr_in,
  input  logic [BITS-1:0] y_in,
  output logic            fp,
  output logic            bp,
  output logic [BITS-1:0] dz_out,
  output logic [BITS-1:0] w_out,
  output logic [BITS-1:0] lr_out,
  output logic [BITS-1:0] y_cap,
  output logic            err_valid,
  output logic            busy,
  output logic            done
);

  localparam int MAX_LEN = (FWD_LEN > BWD_LEN) ? FWD_LEN : BWD_LEN;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0]   FWD_LAST = CW'(FWD_LEN - 1);
  localparam logic [CW-1:0]   BWD_LAST = CW'(BWD_LEN - 1);
  localparam logic [BITS-1:0] W_ONE    = BITS'(Q_ONE);

  if (N % 2 != 0) begin : g_bad_n
    $error("train_step_ctrl: N must be even");
  end

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BITS-1:0] r_target;
  logic [BITS-1:0] r_lr;
  logic [BITS-1:0] r_dz;
  logic [BITS-1:0] r_y;
  logic            r_fp;
  logic            r_bp;
  logic            r_err_valid;
  logic            r_busy;
  logic            r_done;
  logic [BITS-1:0] w_dz;

  sat_sub #(.BITS(BITS)) u_sat_sub (
    .i_a (y_in),
    .i_b (r_target),
    .o_y (w_dz)
  );

  // Phase pins, busy and done are registered alongside the state so they change with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_target    <= '0;
      r_lr        <= '0;
      r_dz        <= '0;
      r_y         <= '0;
      {r_fp, r_bp} <= PH_FSETUP;
      r_err_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_target     <= target;
            r_lr         <= lr_in;
            r_err_valid  <= 1'b0;
            r_cnt        <= '0;
            r_state      <= ST_FWD;
            {r_fp, r_bp} <= PH_FWD;
            r_busy       <= 1'b1;
          end
        end
        ST_FWD: begin
          if (r_cnt == FWD_LAST) begin
            r_y          <= y_in;
            r_dz         <= w_dz;
            r_err_valid  <= 1'b1;
            r_cnt        <= '0;
            r_state      <= ST_ERR;
            {r_fp, r_bp} <= PH_BSETUP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ERR: begin
          r_cnt        <= '0;
          r_state      <= ST_BWD;
          {r_fp, r_bp} <= PH_BWD;
        end
        ST_BWD: begin
          if (r_cnt == BWD_LAST) begin
            r_cnt        <= '0;
            r_state      <= ST_DONE;
            {r_fp, r_bp} <= PH_FSETUP;
            r_done       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_IDLE;
          {r_fp, r_bp} <= PH_FSETUP;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign fp        = r_fp;
  assign bp        = r_bp;
  assign dz_out    = r_dz;
  assign w_out     = W_ONE;
  assign lr_out    = r_lr;
  assign y_cap     = r_y;
  assign err_valid = r_err_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_train_step_ctrl.sv
// Directed-vector bench for train_step_ctrl with N=6 (FWD_LEN=6, BWD_LEN=9).
module tb_train_step_ctrl;

  localparam int N       = 6;
  localparam int BITS    = 16;
  localparam int FWD_LEN = 6;
  localparam int BWD_LEN = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] target = '0;
  logic [BITS-1:0] lr_in = '0;
  logic [BITS-1:0] y_in = '0;
  logic            fp, bp, err_valid, busy, done;
  logic [BITS-1:0] dz_out, w_out, lr_out, y_cap;

  train_step_ctrl #(.N(N), .BITS(BITS), .FWD_LEN(FWD_LEN), .BWD_LEN(BWD_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .target    (target),
    .lr_in     (lr_in),
    .y_in      (y_in),
    .fp        (fp),
    .bp        (bp),
    .dz_out    (dz_out),
    .w_out     (w_out),
    .lr_out    (lr_out),
    .y_cap     (y_cap),
    .err_valid (err_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int              m_fp, m_err, m_bwd, m_done_at, m_done_n, m_busy;
  logic [BITS-1:0] m_dz, m_y, m_lr;
  logic            m_ev, m_first_fp;

  // One step: start accepted at edge 0, observe cycles 1..22 at the falling edge.
  // y_in carries the real value only across the last FWD edge; target/lr_in are
  // scrambled after acceptance. Extra start pulses may be placed at cycles pa/pb.
  task automatic run_step(input logic [BITS-1:0] tgt, input logic [BITS-1:0] yv,
                          input logic [BITS-1:0] lr, input int pa, input int pb);
    m_fp = 0; m_err = 0; m_bwd = 0; m_done_at = 0; m_done_n = 0; m_busy = 0;
    m_dz = '0; m_y = '0; m_lr = '0; m_ev = 1'b0; m_first_fp = 1'b0;
    @(negedge clk);
    target = tgt; lr_in = lr; y_in = ~yv; start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      case ({fp, bp})
        2'b10: m_fp++;
        2'b11: begin m_err++; m_dz = dz_out; m_y = y_cap; m_ev = err_valid; m_lr = lr_out; end
        2'b01: m_bwd++;
        default: ;
      endcase
      if (done) begin
        m_done_n++;
        if (m_done_at == 0) m_done_at = c;
      end
      if (busy) m_busy++;
      if (c == 1) m_first_fp = fp;
      start = (c == pa) || (c == pb);
      if (c == 2) begin target = ~tgt; lr_in = ~lr; end
      y_in = (c == FWD_LEN) ? yv : ~yv;
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_phase", {30'd0, fp, bp}, 32'h0);
    check("idle_busy", busy, 1'b0);
    check("idle_w", w_out, 16'h0100);
    check("idle_dz", dz_out, 16'h0000);
    check("idle_ev", err_valid, 1'b0);

    // Basic step, with ignored start pulses in BWD (cycle 10) and DONE (cycle 17)
    run_step(16'h0080, 16'h0200, 16'h0010, 10, 17);
    check("basic_first_fp", m_first_fp, 1'b1);
    check("basic_fwd_cycles", m_fp, 6);
    check("basic_err_cycles", m_err, 1);
    check("basic_dz", m_dz, 16'h0180);
    check("basic_ycap", m_y, 16'h0200);
    check("basic_ev_in_err", m_ev, 1'b1);
    check("basic_lr_in_err", m_lr, 16'h0010);
    check("basic_bwd_cycles", m_bwd, 9);
    check("basic_done_at", m_done_at, 17);
    check("basic_done_count", m_done_n, 1);
    check("basic_busy_cycles", m_busy, 17);
    check("basic_ev_held", err_valid, 1'b1);

    // Saturation and a plain negative result
    run_step(16'h9000, 16'h7000, 16'h0020, 0, 0);
    check("sat_pos_dz", m_dz, 16'h7FFF);
    run_step(16'h7000, 16'h9000, 16'h0020, 0, 0);
    check("sat_neg_dz", m_dz, 16'h8000);
    run_step(16'h0100, 16'h0040, 16'h0020, 0, 0);
    check("neg_dz", m_dz, 16'hFF40);

    // start held high: one IDLE cycle between DONE and the next FWD
    @(negedge clk);
    target = 16'h0000; y_in = 16'h0100; lr_in = 16'h0011; start = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      if (c == 3)  lr_in = 16'h0022;
      if (c == 10) check("hold_lr_step1", lr_out, 16'h0011);
      if (c == 17) check("hold_done1", done, 1'b1);
      if (c == 18) begin
        check("hold_gap_phase", {30'd0, fp, bp}, 32'h0);
        check("hold_gap_busy", busy, 1'b0);
      end
      if (c == 19) begin
        check("hold_fwd2", fp, 1'b1);
        check("hold_lr_step2", lr_out, 16'h0022);
      end
      if (c == 35) check("hold_done2", done, 1'b1);
      if (c == 36) check("hold_gap2_phase", {30'd0, fp, bp}, 32'h0);
      if (c == 37) check("hold_fwd3", fp, 1'b1);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Reset during FWD count 3 (cycle 4)
    @(negedge clk);
    target = 16'h0000; lr_in = 16'h0033; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_fp", fp, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_phase", {30'd0, fp, bp}, 32'h0);
    check("rst_ev", err_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", dz_out, 16'h0000);
    check("rst_ycap", y_cap, 16'h0000);
    check("rst_lr", lr_out, 16'h0000);
    check("rst_w", w_out, 16'h0100);
    rst_n = 1'b1;

    run_step(16'h0100, 16'h0300, 16'h0044, 0, 0);
    check("post_rst_dz", m_dz, 16'h0200);
    check("post_rst_fwd", m_fp, 6);
    check("post_rst_done_at", m_done_at, 17);
    check("post_rst_busy", m_busy, 17);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/train_step_ctrl.md
# train_step_ctrl

Sequencer and error stage for the output-layer neuron (`Neuron_ReLU` instance).
- Drives the neuron's `{FP,BP}` phase pins through one forward pass, an error computation and one backward pass per `start` pulse.
- Captures the neuron's `y` and computes the Q8.8 output error `dz = y - target`, saturated.
- Presents `dz`, `W_in = 1.0` and `lr` to the neuron at backward setup.
- Sits directly downstream of the neuron's `y` output and upstream of its `dZ_in`/`W_in`/`lr` inputs.

## Interface
Parameters:
- `N`, 6: neuron fan-in. Must be even.
- `BITS`, 16: data width, signed Q8.8.
- `FWD_LEN`, N/2+3: cycles spent in forward propagation.
- `BWD_LEN`, N+3: cycles spent in backward propagation.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: begin one training step. Sampled only in IDLE.
- `target` input BITS: desired output. Latched on accepted `start`.
- `lr_in` input BITS: learning rate. Latched on accepted `start`.
- `y_in` input BITS: neuron output.
- `fp` output 1: neuron FP pin.
- `bp` output 1: neuron BP pin.
- `dz_out` output BITS: saturated error, drives neuron `dZ_in`.
- `w_out` output BITS: drives neuron `W_in`. Always 16'h0100 outside reset.
- `lr_out` output BITS: latched learning rate.
- `y_cap` output BITS: captured forward result.
- `err_valid` output 1: high while `dz_out` and `y_cap` hold this step's values. Held from ERR until next accepted `start`.
- `busy` output 1: high in FWD, ERR, BWD and DONE.
- `done` output 1: one-cycle pulse in DONE.

## Operation
The state machine has five states, each with a fixed `{fp,bp}`:
- IDLE, 00 (forward setup):
  - Neuron re-primes continuously.
  - On `start`: latch `target` and `lr_in`, clear `err_valid`, clear the counter, go to FWD.
- FWD, 10:
  - Counter counts 0..FWD_LEN-1.
  - On count FWD_LEN-1: register `y_in` into `y_cap` and the saturated difference into `dz_out`, then go to ERR.
- ERR, 11 (backward setup):
  - Lasts exactly 1 cycle.
  - `dz_out`, `w_out` and `lr_out` are stable, so the neuron latches them at this edge.
  - `err_valid` is set. Counter cleared. Go to BWD.
- BWD, 01:
  - Counter counts 0..BWD_LEN-1, then go to DONE.
- DONE, 00:
  - `done` = 1 for exactly 1 cycle, then go to IDLE.

Arithmetic:
- `dz` is computed in BITS+1 bits as sign-extended `y_in` minus sign-extended `target`.
- Results above 16'h7FFF clamp to 16'h7FFF. Results below 16'h8000 clamp to 16'h8000.
- There is no rounding.

Boundary conditions:
- `start` outside IDLE, including in DONE, is ignored. It is not queued.
- `target` and `lr_in` changes after acceptance have no effect until the next step.
- `y_in` is sampled only on the last FWD cycle.
- A `start` held high continuously begins a new step on every IDLE cycle. Back-to-back steps therefore have exactly one IDLE cycle between DONE and the next FWD, which is the neuron's forward-setup cycle.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. A partial step leaves no residue.

## Timing
- Reset values:
  - state IDLE, so `fp` = 0 and `bp` = 0.
  - `dz_out`, `lr_out`, `y_cap` = 0.
  - `w_out` = 16'h0100.
  - `err_valid`, `busy`, `done` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- With `start` sampled high at edge 0:
  - `fp` = 1 for cycles 1..FWD_LEN.
  - ERR is cycle FWD_LEN+1.
  - BWD is cycles FWD_LEN+2..FWD_LEN+BWD_LEN+1.
  - `done` is at cycle FWD_LEN+BWD_LEN+2.
- `busy` is high for FWD_LEN+BWD_LEN+2 cycles. With N=6 that is 17 cycles.
- `dz_out` and `y_cap` update at the edge ending the last FWD cycle, and are valid throughout ERR.

## Structure
- Shared package `nn_pkg`:
  - Phase encodings: PH_FSETUP=2'b00, PH_FWD=2'b10, PH_BSETUP=2'b11, PH_BWD=2'b01.
  - State enum.
  - Q8.8 constant Q_ONE=16'h0100.
  - Q_MAX=16'h7FFF, Q_MIN=16'h8000.
- One sub-module: `sat_sub`, combinational BITS-wide saturating subtract. `Neuron_ReLU` and future layers will reuse it.
- The counter width is $clog2(max(FWD_LEN,BWD_LEN)).

## Test plan
All scenarios use N=6, FWD_LEN=6, BWD_LEN=9.
- Reset, then idle 5 cycles:
  - `{fp,bp}` = 00, `busy` = 0, `w_out` = 0x0100, `dz_out` = 0.
- `start` with target=0x0080 and `y_in` held at 0x0200:
  - `fp` high for exactly 6 cycles, ERR shows 11 for 1 cycle.
  - `dz_out` = 0x0180 in ERR.
  - BWD lasts 9 cycles, `done` pulses at cycle 17, `busy` spans 17 cycles.
- Saturation, two cases:
  - `y_in`=0x7000, target=0x9000: `dz_out` = 0x7FFF.
  - `y_in`=0x9000, target=0x7000: `dz_out` = 0x8000.
- `start` pulsed during BWD and during DONE: ignored. Exactly one `done` is produced.
- `start` held high continuously: one IDLE cycle with `{fp,bp}`=00 between each DONE and the next FWD. `lr_out` tracks each latched `lr_in`.
- `rst_n` low during FWD count 3:
  - Next cycle IDLE with all reset values, `err_valid` = 0.
  - A subsequent step completes normally.
